rv32im_alu: RTL and testbench

Integer execute-stage ALU for the RV32IM pipeline. Computes base RV32I arithmetic/logic/shift/compare results and M-extension multiply/divide/remainder, selected by a 2-bit ALU opcode plus funct3/funct7. Result and status flags (zero, carry, overflow) are registered, one cycle after the operands are presented.

---
 rtl/rv32im_alu_pkg.sv | 27 ++
 rtl/rv32im_alu_muldiv.sv | 33 +++
 rtl/rv32im_alu.sv | 65 ++++++
 tb/tb_rv32im_alu.sv | 109 ++++++++++
 4 files changed

// File: rtl/rv32im_alu_pkg.sv
// rv32im_alu_pkg: shared encodings and types for the RV32IM execute-stage ALU.
package rv32im_alu_pkg;
  localparam int XLEN = 32;
  localparam logic [1:0] ALU_R   = 2'b00;
  localparam logic [1:0] ALU_I   = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
endpackage

// File: rtl/rv32im_alu_muldiv.sv
// rv32im_alu_muldiv: combinational M-extension multiply/divide/remainder with RISC-V corner cases.
module rv32im_muldiv
  import rv32im_alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  funct3,
  output logic [31:0] y
);
  logic               sa, sb, ds, a_neg, b_neg;
  logic signed [65:0] a_x, b_x, prod;
  logic [31:0]        a_mag, b_mag, q_mag, r_mag, q, r;
  always_comb begin
    sa    = (funct3 == F3_MULH) | (funct3 == F3_MULHSU);
    sb    = funct3 == F3_MULH;
    a_x   = {{34{sa & a[31]}}, a};
    b_x   = {{34{sb & b[31]}}, b};
    prod  = a_x * b_x;
    ds    = ~funct3[0];
    a_neg = ds & a[31];
    b_neg = ds & b[31];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    // guard the zero divisor so the divider never sees x-producing operands
    q_mag = (b == '0) ? '0 : a_mag / b_mag;
    r_mag = (b == '0) ? '0 : a_mag % b_mag;
    q     = (a_neg ^ b_neg) ? -q_mag : q_mag;
    r     = a_neg ? -r_mag : r_mag;
    y     = !funct3[2] ? ((funct3 == F3_MUL) ? prod[31:0] : prod[63:32]) :
            !funct3[1] ? ((b == '0) ? '1 : q) :
                         ((b == '0) ? a : r);
  end
endmodule

// File: rtl/rv32im_alu.sv
// rv32im_alu: RV32IM execute-stage ALU with registered result and zero/carry/overflow flags.
module rv32im_alu
  import rv32im_alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [1:0]  opcode,
  output logic [31:0] result,
  output logic        zero,
  output logic        carry,
  output logic        overflow
);
  logic [31:0] result_d, result_q, base, md;
  logic        zero_d, zero_q, carry_d, carry_q, overflow_d, overflow_q;
  logic        is_m, is_arith, is_sub;
  logic [2:0]  f3;
  logic [32:0] sum, diff;
  rv32im_muldiv u_muldiv (.a(op1), .b(op2), .funct3(funct3), .y(md));
  always_comb begin
    is_m     = (opcode == ALU_R) && (funct7 == F7_MULDIV);
    f3       = opcode[1] ? F3_ADD : funct3;
    is_arith = !is_m && (f3 == F3_ADD);
    // only R-type and the forced-SUB class subtract; ADDI never does
    is_sub   = (opcode == ALU_SUB) || (opcode == ALU_R && funct7[5]);
    sum      = {1'b0, op1} + {1'b0, op2};
    diff     = {1'b0, op1} - {1'b0, op2};
    base     = '0;
    case (f3)
      F3_ADD:  base = is_sub ? diff[31:0] : sum[31:0];
      F3_SLL:  base = op1 << op2[4:0];
      F3_SLT:  base = {31'd0, $signed(op1) < $signed(op2)};
      F3_SLTU: base = {31'd0, op1 < op2};
      F3_XOR:  base = op1 ^ op2;
      F3_SR:   base = funct7[5] ? 32'($signed(op1) >>> op2[4:0]) : op1 >> op2[4:0];
      F3_OR:   base = op1 | op2;
      default: base = op1 & op2;
    endcase
    result_d   = is_m ? md : base;
    zero_d     = result_d == '0;
    carry_d    = is_arith && (is_sub ? diff[32] : sum[32]);
    overflow_d = is_arith && (is_sub ? (op1[31] != op2[31]) && (diff[31] != op1[31])
                                     : (op1[31] == op2[31]) && (sum[31] != op1[31]));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q   <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
    end
  end
  assign result   = result_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_rv32im_alu.sv
// tb_rv32im_alu: directed-vector self-checking bench for rv32im_alu.
module tb_rv32im_alu;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] op1 = '0, op2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [1:0]  opcode = '0;
  logic [31:0] result;
  logic        zero, carry, overflow;
  int          total = 0, bad = 0;
  always #5 clk = ~clk;
  rv32im_alu dut (
    .clk(clk), .reset(reset), .op1(op1), .op2(op2), .funct3(funct3),
    .funct7(funct7), .opcode(opcode), .result(result), .zero(zero),
    .carry(carry), .overflow(overflow)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [1:0] opc);
    op1 = a; op2 = b; funct3 = f3; funct7 = f7; opcode = opc;
    @(posedge clk);
    #1;
  endtask
  task automatic expect_out(input string tag, input logic [31:0] r, input logic z,
                            input logic c, input logic v);
    chk({tag, ".result"}, result, r);
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, z});
    chk({tag, ".carry"}, {31'd0, carry}, {31'd0, c});
    chk({tag, ".overflow"}, {31'd0, overflow}, {31'd0, v});
  endtask
  initial begin
    run(32'd5, 32'd7, 3'b000, 7'd0, 2'b00);
    expect_out("reset0", 32'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    run(32'd1, 32'd2, 3'b000, 7'd0, 2'b00);
    expect_out("add", 32'd3, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    run(32'hFFFFFFFF, 32'd1, 3'b000, 7'd0, 2'b00);
    expect_out("reset1", 32'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    run(32'd1, 32'd2, 3'b010, 7'd0, 2'b01);
    expect_out("slti", 32'd1, 1'b0, 1'b0, 1'b0);
    run(32'hFFFFFFFF, 32'd1, 3'b011, 7'd0, 2'b01);
    expect_out("sltiu", 32'd0, 1'b1, 1'b0, 1'b0);
    run(32'hFFFFFFFF, 32'd1, 3'b010, 7'd0, 2'b00);
    expect_out("slt_neg", 32'd1, 1'b0, 1'b0, 1'b0);
    run(32'hAAAAAAAA, 32'h55555555, 3'b100, 7'd0, 2'b00);
    expect_out("xor", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    run(32'hAAAAAAAA, 32'h0000FFFF, 3'b110, 7'd0, 2'b01);
    expect_out("ori", 32'hAAAAFFFF, 1'b0, 1'b0, 1'b0);
    run(32'hAAAAAAAA, 32'h0000FFFF, 3'b111, 7'd0, 2'b01);
    expect_out("andi", 32'h0000AAAA, 1'b0, 1'b0, 1'b0);
    run(32'h7FFFFFFF, 32'd1, 3'b111, 7'd1, 2'b10);
    expect_out("add_ovf", 32'h80000000, 1'b0, 1'b0, 1'b1);
    run(32'hFFFFFFFF, 32'd1, 3'b000, 7'd0, 2'b10);
    expect_out("add_carry", 32'd0, 1'b1, 1'b1, 1'b0);
    run(32'd1, 32'd2, 3'b000, 7'b0100000, 2'b00);
    expect_out("sub_borrow", 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
    run(32'h80000000, 32'd1, 3'b101, 7'b0000001, 2'b11);
    expect_out("sub_ovf", 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1);
    run(32'd5, 32'd5, 3'b110, 7'd0, 2'b11);
    expect_out("sub_zero", 32'd0, 1'b1, 1'b0, 1'b0);
    run(32'd1, 32'd2, 3'b000, 7'b0100000, 2'b01);
    expect_out("addi_alt", 32'd3, 1'b0, 1'b0, 1'b0);
    run(32'h80000000, 32'd4, 3'b101, 7'b0100000, 2'b00);
    expect_out("sra", 32'hF8000000, 1'b0, 1'b0, 1'b0);
    run(32'h80000000, 32'd4, 3'b101, 7'b0100000, 2'b01);
    expect_out("srai", 32'hF8000000, 1'b0, 1'b0, 1'b0);
    run(32'h80000000, 32'd4, 3'b101, 7'd0, 2'b00);
    expect_out("srl", 32'h08000000, 1'b0, 1'b0, 1'b0);
    run(32'd1, 32'd31, 3'b001, 7'd0, 2'b00);
    expect_out("sll", 32'h80000000, 1'b0, 1'b0, 1'b0);
    run(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b011, 7'd1, 2'b00);
    expect_out("mulhu", 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    run(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b001, 7'd1, 2'b00);
    expect_out("mulh", 32'd0, 1'b1, 1'b0, 1'b0);
    run(32'hFFFFFFFF, 32'd2, 3'b010, 7'd1, 2'b00);
    expect_out("mulhsu", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    run(32'd3, 32'hFFFFFFFE, 3'b000, 7'd1, 2'b00);
    expect_out("mul", 32'hFFFFFFFA, 1'b0, 1'b0, 1'b0);
    run(32'hFFFFFFF9, 32'd2, 3'b100, 7'd1, 2'b00);
    expect_out("div", 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0);
    run(32'hFFFFFFF9, 32'd2, 3'b110, 7'd1, 2'b00);
    expect_out("rem", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    run(32'd7, 32'hFFFFFFFE, 3'b110, 7'd1, 2'b00);
    expect_out("rem_pos", 32'd1, 1'b0, 1'b0, 1'b0);
    run(32'h00001234, 32'd0, 3'b101, 7'd1, 2'b00);
    expect_out("divu0", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    run(32'h00001234, 32'd0, 3'b111, 7'd1, 2'b00);
    expect_out("remu0", 32'h00001234, 1'b0, 1'b0, 1'b0);
    run(32'hFFFFFFF9, 32'd0, 3'b100, 7'd1, 2'b00);
    expect_out("div0", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    run(32'hFFFFFFF0, 32'd3, 3'b101, 7'd1, 2'b00);
    expect_out("divu", 32'h55555550, 1'b0, 1'b0, 1'b0);
    run(32'h80000000, 32'hFFFFFFFF, 3'b100, 7'd1, 2'b00);
    expect_out("div_ovf", 32'h80000000, 1'b0, 1'b0, 1'b0);
    run(32'h80000000, 32'hFFFFFFFF, 3'b110, 7'd1, 2'b00);
    expect_out("rem_ovf", 32'd0, 1'b1, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
